// File: rtl/qcw_burst_scheduler.sv
// qcw_burst_scheduler
// Sequences the QCW power stage through a train of bursts at a programmed
// repetition period. It drives start, the cycle limit and the per-cycle
// phase-shift ramp, enforces a minimum off-time between bursts and latches
// faults until they are cleared.
// Optional feature: define QCW_SCHED_WATCHDOG_EN to add a RUN-state burst
// watchdog and the wd_trip output.
module qcw_burst_scheduler #(
  parameter int PERIOD_W      = 24,
  parameter int MIN_OFF_CLKS  = 4096,
  parameter int WATCHDOG_CLKS = 1000000
) (
  input  logic                wb_clk_i,
  input  logic                wb_rst_ni,
  input  logic                cfg_enable,
  input  logic [15:0]         cfg_burst_count,
  input  logic [PERIOD_W-1:0] cfg_rep_period,
  input  logic [15:0]         cfg_cycle_limit,
  input  logic [7:0]          cfg_phase_start,
  input  logic [15:0]         cfg_phase_step,
  input  logic                fault_clear,
  input  logic                qcw_done,
  input  logic                qcw_cycle_finished,
  input  logic                qcw_fault,
  input  logic                qcw_halt,
  output logic                qcw_start,
  output logic [15:0]         qcw_cycle_limit,
  output logic [7:0]          qcw_phase_shift,
  output logic                busy,
  output logic                fault_latched,
`ifdef QCW_SCHED_WATCHDOG_EN
  output logic                wd_trip,
`endif
  output logic [15:0]         bursts_done
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_RUN,
    ST_HOLDOFF,
    ST_LOCKOUT
  } state_t;

  state_t state, state_nxt;

  logic [15:0]         sh_burst_count;
  logic [PERIOD_W-1:0] sh_rep_period;
  logic [7:0]          sh_phase_start;
  logic [15:0]         sh_phase_step;

  logic [15:0]         cycle_cnt;
  logic [23:0]         accum;
  logic [PERIOD_W-1:0] period_cnt;
  logic [PERIOD_W-1:0] off_cnt;
  logic                done_q;

  logic [PERIOD_W-1:0] period_dec;
  logic [PERIOD_W-1:0] off_dec;
  logic [23:0]         accum_new;
  logic [16:0]         phase_sum;
  logic [7:0]          phase_sat;
  logic [15:0]         bursts_inc;
  logic                burst_end;
  logic                train_done;
  logic                fault_evt;
  logic                burst_fin;

`ifdef QCW_SCHED_WATCHDOG_EN
  logic [PERIOD_W-1:0] wd_cnt;
  logic                wd_hit;
  assign wd_hit = (state == ST_RUN) && (wd_cnt >= PERIOD_W'(WATCHDOG_CLKS));
`else
  logic                wd_hit;
  assign wd_hit = 1'b0;
`endif

  assign qcw_start     = (state == ST_START);
  assign busy          = (state == ST_START) || (state == ST_RUN) || (state == ST_HOLDOFF);
  assign fault_latched = (state == ST_LOCKOUT);

  // Counter decrements, phase ramp arithmetic and burst-end decode
  always_comb begin
    period_dec = (period_cnt == '0) ? '0 : period_cnt - 1'b1;
    off_dec    = (off_cnt == '0) ? '0 : off_cnt - 1'b1;
    accum_new  = accum + {8'd0, sh_phase_step};
    phase_sum  = {9'd0, sh_phase_start} + {1'b0, accum_new[23:8]};
    phase_sat  = (phase_sum > 17'd255) ? 8'hFF : phase_sum[7:0];
    bursts_inc = bursts_done + 16'd1;
    burst_end  = (qcw_done && !done_q) || (cycle_cnt >= qcw_cycle_limit);
    train_done = (sh_burst_count != 16'd0) && (bursts_inc == sh_burst_count);
    fault_evt  = qcw_fault || wd_hit;
    burst_fin  = (state == ST_RUN) && !fault_evt && !qcw_halt && burst_end;
  end

  // Next-state decode; fault beats halt, halt beats burst end
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cfg_enable) state_nxt = ST_START;
      end
      ST_START: begin
        if (fault_evt)     state_nxt = ST_LOCKOUT;
        else if (qcw_halt) state_nxt = ST_IDLE;
        else               state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (fault_evt)      state_nxt = ST_LOCKOUT;
        else if (qcw_halt)  state_nxt = ST_IDLE;
        else if (burst_end) state_nxt = train_done ? ST_IDLE : ST_HOLDOFF;
      end
      ST_HOLDOFF: begin
        if (fault_evt)        state_nxt = ST_LOCKOUT;
        else if (qcw_halt)    state_nxt = ST_IDLE;
        else if (!cfg_enable) state_nxt = ST_IDLE;
        else if ((period_dec == '0) && (off_dec == '0)) state_nxt = ST_START;
      end
      ST_LOCKOUT: begin
        if (fault_clear && !qcw_fault) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) state <= ST_IDLE;
    else            state <= state_nxt;
  end

  // Shadow config, counters and phase ramp; the period counter is loaded on
  // entry to START so that start-to-start spacing equals rep_period exactly
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sh_burst_count  <= '0;
      sh_rep_period   <= '0;
      sh_phase_start  <= '0;
      sh_phase_step   <= '0;
      qcw_cycle_limit <= '0;
      qcw_phase_shift <= '0;
      bursts_done     <= '0;
      cycle_cnt       <= '0;
      accum           <= '0;
      period_cnt      <= '0;
      off_cnt         <= '0;
      done_q          <= 1'b0;
    end else begin
      done_q <= qcw_done;
      case (state)
        ST_IDLE: begin
          if (cfg_enable) begin
            sh_burst_count  <= cfg_burst_count;
            sh_rep_period   <= cfg_rep_period;
            sh_phase_start  <= cfg_phase_start;
            sh_phase_step   <= cfg_phase_step;
            qcw_cycle_limit <= cfg_cycle_limit;
            qcw_phase_shift <= cfg_phase_start;
            period_cnt      <= cfg_rep_period;
            bursts_done     <= '0;
          end
        end
        ST_START: begin
          cycle_cnt  <= '0;
          accum      <= '0;
          period_cnt <= period_dec;
        end
        ST_RUN: begin
          period_cnt <= period_dec;
          if (qcw_cycle_finished) begin
            cycle_cnt       <= cycle_cnt + 16'd1;
            accum           <= accum_new;
            qcw_phase_shift <= phase_sat;
          end
          if (burst_fin) begin
            bursts_done <= bursts_inc;
            off_cnt     <= PERIOD_W'(MIN_OFF_CLKS);
          end
        end
        ST_HOLDOFF: begin
          period_cnt <= period_dec;
          off_cnt    <= off_dec;
          if (state_nxt == ST_START) begin
            qcw_phase_shift <= sh_phase_start;
            period_cnt      <= sh_rep_period;
          end
        end
        default: ;
      endcase
      if ((state_nxt == ST_IDLE) || (state_nxt == ST_LOCKOUT)) qcw_phase_shift <= '0;
    end
  end

`ifdef QCW_SCHED_WATCHDOG_EN
  // Burst watchdog: counts RUN clocks and flags the trip until LOCKOUT is left
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wd_cnt  <= '0;
      wd_trip <= 1'b0;
    end else begin
      if (state == ST_START)    wd_cnt <= '0;
      else if (state == ST_RUN) wd_cnt <= wd_cnt + 1'b1;
      if (wd_hit && !qcw_fault) wd_trip <= 1'b1;
      else if ((state == ST_LOCKOUT) && (state_nxt == ST_IDLE)) wd_trip <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_qcw_burst_scheduler.sv
// tb_qcw_burst_scheduler
// Scoreboard bench: expected phase values and start spacings are queued as
// stimulus is applied and compared when the scheduler produces its outputs.
module tb_qcw_burst_scheduler;

  localparam int PERIOD_W = 24;
  localparam int MIN_OFF  = 4096;

  logic                wb_clk_i = 1'b0;
  logic                wb_rst_ni;
  logic                cfg_enable;
  logic [15:0]         cfg_burst_count;
  logic [PERIOD_W-1:0] cfg_rep_period;
  logic [15:0]         cfg_cycle_limit;
  logic [7:0]          cfg_phase_start;
  logic [15:0]         cfg_phase_step;
  logic                fault_clear;
  logic                qcw_done;
  logic                qcw_cycle_finished;
  logic                qcw_fault;
  logic                qcw_halt;
  logic                qcw_start;
  logic [15:0]         qcw_cycle_limit;
  logic [7:0]          qcw_phase_shift;
  logic                busy;
  logic                fault_latched;
  logic [15:0]         bursts_done;
`ifdef QCW_SCHED_WATCHDOG_EN
  logic                wd_trip;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int startCount = 0;
  int expQ[$];
  int modelAccum;
  int modelPhaseStart;
  int modelStep;

  qcw_burst_scheduler #(
    .PERIOD_W(PERIOD_W),
    .MIN_OFF_CLKS(MIN_OFF),
    .WATCHDOG_CLKS(1000000)
  ) dut (
    .wb_clk_i(wb_clk_i),
    .wb_rst_ni(wb_rst_ni),
    .cfg_enable(cfg_enable),
    .cfg_burst_count(cfg_burst_count),
    .cfg_rep_period(cfg_rep_period),
    .cfg_cycle_limit(cfg_cycle_limit),
    .cfg_phase_start(cfg_phase_start),
    .cfg_phase_step(cfg_phase_step),
    .fault_clear(fault_clear),
    .qcw_done(qcw_done),
    .qcw_cycle_finished(qcw_cycle_finished),
    .qcw_fault(qcw_fault),
    .qcw_halt(qcw_halt),
    .qcw_start(qcw_start),
    .qcw_cycle_limit(qcw_cycle_limit),
    .qcw_phase_shift(qcw_phase_shift),
    .busy(busy),
    .fault_latched(fault_latched),
`ifdef QCW_SCHED_WATCHDOG_EN
    .wd_trip(wd_trip),
`endif
    .bursts_done(bursts_done)
  );

  // 100 MHz clock
  always #5 wb_clk_i = ~wb_clk_i;

  // Clock counter used to measure start-to-start spacing
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  // Start pulses are counted on the inactive edge
  always @(negedge wb_clk_i) if (qcw_start === 1'b1) startCount = startCount + 1;

  // Hard time limit so the run always ends
  initial begin
    #1500000;
    $display("[TB] FAIL global_timeout: simulation did not complete, got timeout, required completion");
    $fatal(1, "[TB] global timeout");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge wb_clk_i);
  endtask

  task automatic configure(input int bc, input int rp, input int cl, input int ps, input int st);
    cfg_burst_count = 16'(bc);
    cfg_rep_period  = PERIOD_W'(rp);
    cfg_cycle_limit = 16'(cl);
    cfg_phase_start = 8'(ps);
    cfg_phase_step  = 16'(st);
    modelPhaseStart = ps;
    modelStep       = st;
    modelAccum      = 0;
  endtask

  // One resonant-cycle pulse; the model predicts the saturated phase
  task automatic applyStimulus(input string tag);
    int sum;
    modelAccum = (modelAccum + modelStep) & 24'hFFFFFF;
    sum = modelPhaseStart + (modelAccum >> 8);
    expQ.push_back((sum > 255) ? 255 : sum);
    qcw_cycle_finished = 1'b1;
    step();
    qcw_cycle_finished = 1'b0;
    checkOutput(tag, 32'(qcw_phase_shift), expQ.pop_front());
  endtask

  task automatic waitStart(input int budget, output int when);
    when = -1;
    for (int i = 0; i < budget; i++) begin
      if (qcw_start === 1'b1) begin
        when = cyc;
        break;
      end
      step();
    end
    if (when < 0) checkOutput("start_timeout", 0, 1);
    modelAccum = 0;
  endtask

  initial begin
    int t, t0, t1, prev, s0, sawStart;
    wb_rst_ni = 1'b0;
    cfg_enable = 1'b0;
    fault_clear = 1'b0;
    qcw_done = 1'b0;
    qcw_cycle_finished = 1'b0;
    qcw_fault = 1'b0;
    qcw_halt = 1'b0;
    configure(0, 0, 0, 0, 0);
    step(2);
    checkOutput("rst_start", 32'(qcw_start), 0);
    checkOutput("rst_phase", 32'(qcw_phase_shift), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_fault", 32'(fault_latched), 0);
    checkOutput("rst_bursts", 32'(bursts_done), 0);
    checkOutput("rst_cyclim", 32'(qcw_cycle_limit), 0);
    wb_rst_ni = 1'b1;
    step(2);

    $display("[TB] single burst");
    configure(1, 1000, 5, 10, 16'h0180);
    s0 = startCount;
    cfg_enable = 1'b1;
    waitStart(10, t);
    checkOutput("single_phase0", 32'(qcw_phase_shift), 10);
    checkOutput("single_busy", 32'(busy), 1);
    cfg_enable = 1'b0;
    step();
    checkOutput("single_cyclim", 32'(qcw_cycle_limit), 5);
    for (int i = 0; i < 5; i++) applyStimulus("single_phase");
    step();
    checkOutput("single_end_busy", 32'(busy), 0);
    checkOutput("single_bursts", 32'(bursts_done), 1);
    checkOutput("single_end_phase", 32'(qcw_phase_shift), 0);
    step(5);
    checkOutput("single_starts", 32'(startCount - s0), 1);

    $display("[TB] zero cycle limit");
    configure(1, 10, 0, 7, 16'h0100);
    cfg_enable = 1'b1;
    waitStart(10, t);
    cfg_enable = 1'b0;
    checkOutput("zero_phase0", 32'(qcw_phase_shift), 7);
    step(2);
    checkOutput("zero_busy", 32'(busy), 0);
    checkOutput("zero_bursts", 32'(bursts_done), 1);

    $display("[TB] saturation");
    configure(1, 1000, 4, 250, 16'h0400);
    cfg_enable = 1'b1;
    waitStart(10, t);
    cfg_enable = 1'b0;
    step();
    for (int i = 0; i < 4; i++) applyStimulus("sat_phase");
    step();
    checkOutput("sat_busy", 32'(busy), 0);

    $display("[TB] repetition");
    configure(3, 20000, 4, 0, 16'h0100);
    s0 = startCount;
    prev = 0;
    cfg_enable = 1'b1;
    for (int b = 0; b < 3; b++) begin
      waitStart(25000, t);
      if (b > 0) begin
        expQ.push_back(20000);
        checkOutput("rep_spacing", 32'(t - prev), expQ.pop_front());
      end
      prev = t;
      if (b == 2) cfg_enable = 1'b0;
      step();
      for (int i = 0; i < 4; i++) applyStimulus("rep_phase");
    end
    for (int i = 0; i < 20 && busy === 1'b1; i++) step();
    checkOutput("rep_busy", 32'(busy), 0);
    checkOutput("rep_bursts", 32'(bursts_done), 3);
    step(50);
    checkOutput("rep_starts", 32'(startCount - s0), 3);

    $display("[TB] off-time guard");
    configure(0, 100, 1000, 0, 16'h0000);
    cfg_enable = 1'b1;
    waitStart(10, t0);
    step(50);
    qcw_done = 1'b1;
    step();
    qcw_done = 1'b0;
    waitStart(6000, t1);
    cfg_enable = 1'b0;
    expQ.push_back(50 + MIN_OFF + 1);
    checkOutput("off_spacing", 32'(t1 - t0), expQ.pop_front());
    step();
    qcw_halt = 1'b1;
    step();
    qcw_halt = 1'b0;
    checkOutput("halt_busy", 32'(busy), 0);
    checkOutput("halt_fault", 32'(fault_latched), 0);

    $display("[TB] fault lockout");
    configure(0, 1000, 100, 30, 16'h0100);
    cfg_enable = 1'b1;
    waitStart(10, t);
    cfg_enable = 1'b0;
    step();
    applyStimulus("fault_phase");
    qcw_fault = 1'b1;
    step();
    checkOutput("lock_fault", 32'(fault_latched), 1);
    checkOutput("lock_phase", 32'(qcw_phase_shift), 0);
    checkOutput("lock_busy", 32'(busy), 0);
    checkOutput("lock_start", 32'(qcw_start), 0);
    fault_clear = 1'b1;
    step();
    fault_clear = 1'b0;
    checkOutput("clear_ignored", 32'(fault_latched), 1);
    qcw_fault = 1'b0;
    step();
    checkOutput("lock_held", 32'(fault_latched), 1);
    fault_clear = 1'b1;
    step();
    fault_clear = 1'b0;
    checkOutput("clear_taken", 32'(fault_latched), 0);
    checkOutput("clear_busy", 32'(busy), 0);

    $display("[TB] async reset in RUN");
    configure(0, 1000, 100, 40, 16'h0200);
    cfg_enable = 1'b1;
    waitStart(10, t);
    cfg_enable = 1'b0;
    step();
    applyStimulus("arst_phase");
    checkOutput("arst_cyclim_pre", 32'(qcw_cycle_limit), 100);
    #1 wb_rst_ni = 1'b0;
    #1;
    checkOutput("arst_start", 32'(qcw_start), 0);
    checkOutput("arst_phase0", 32'(qcw_phase_shift), 0);
    checkOutput("arst_busy", 32'(busy), 0);
    checkOutput("arst_cyclim", 32'(qcw_cycle_limit), 0);
    checkOutput("arst_bursts", 32'(bursts_done), 0);
    step(2);
    wb_rst_ni = 1'b1;
    sawStart = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (qcw_start !== 1'b0) sawStart = 1;
    end
    checkOutput("arst_no_start", 32'(sawStart), 0);
    cfg_enable = 1'b1;
    waitStart(10, t);
    cfg_enable = 1'b0;
    checkOutput("arst_restart_phase", 32'(qcw_phase_shift), 40);
    step();
    qcw_halt = 1'b1;
    step();
    qcw_halt = 1'b0;
    checkOutput("arst_end_busy", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
